// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//   Write-side front end of the 3-port register file. It merges single-cycle
//   ALU results and variable-latency LSU results into the one write port
//   (A3/WD3/WE3). LSU results queue in an in-order FIFO. An ALU write to the
//   same register squashes older queued LSU writes (WAW). Combinational bypass
//   covers values that have not yet reached the register file.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   NORMAL | ALU has priority on the write port; FIFO drains in idle slots
//   DRAIN  | one forced cycle: ALU stalled, FIFO head popped, back to NORMAL
//
// Ports
//   CLK, RESETn          clock (rising edge), synchronous active-low reset
//   ALU_V/A/D, ALU_RDY   ALU result handshake (ready is low in DRAIN/reset)
//   LSU_V/A/D, LSU_RDY   LSU result handshake (ready = FIFO not full)
//   A3, WD3, WE3         registered register-file write port
//   A1, A2               read addresses to check for bypass
//   BYPn_HIT, BYPn_D     newer uncommitted value for A1/A2 (data 0 on miss)

module regfile_writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        ALU_V,
    input  logic [4:0]  ALU_A,
    input  logic [31:0] ALU_D,
    output logic        ALU_RDY,
    input  logic        LSU_V,
    input  logic [4:0]  LSU_A,
    input  logic [31:0] LSU_D,
    output logic        LSU_RDY,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic        BYP1_HIT,
    output logic        BYP2_HIT,
    output logic [31:0] BYP1_D,
    output logic [31:0] BYP2_D
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX) + 1;

    typedef enum logic {ST_NORMAL = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [4:0]      fifo_a [DEPTH];
    logic [31:0]     fifo_d [DEPTH];
    logic [DEPTH-1:0] fifo_vld;
    logic [AW-1:0]   rptr, wptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;

    logic fifo_empty, fifo_full, head_live;
    logic alu_acc, alu_wr, lsu_push, pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign head_live  = !fifo_empty && fifo_vld[rptr];

    assign alu_acc  = ALU_V && ALU_RDY;
    assign alu_wr   = alu_acc && (ALU_A != 5'd0);
    assign lsu_push = LSU_V && LSU_RDY;
    // DRAIN forces the pop; in NORMAL a nonzero ALU write wins the port.
    // ALU_RDY is low in DRAIN so alu_wr cannot be set there.
    assign pop      = !fifo_empty && ((state == ST_DRAIN) || !alu_wr);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (!RESETn) state <= ST_NORMAL;
        else         state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_NORMAL: if (head_live && !pop && (starve_cnt == SW'(STARVE_MAX - 1)))
                           state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_NORMAL;
            default:   state_nxt = ST_NORMAL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ALU_RDY = RESETn && (state == ST_NORMAL);
        LSU_RDY = RESETn && !fifo_full;
    end

    // ---------------- starve counter ----------------
    always_ff @(posedge CLK) begin
        if (!RESETn)
            starve_cnt <= '0;
        else if (fifo_empty || pop)
            starve_cnt <= '0;
        else if ((state == ST_NORMAL) && head_live && (starve_cnt != '1))
            starve_cnt <= starve_cnt + 1'b1;
    end

    // ---------------- FIFO storage ----------------
    always_ff @(posedge CLK) begin
        if (lsu_push) begin
            fifo_a[wptr] <= LSU_A;
            fifo_d[wptr] <= LSU_D;
        end
    end

    // Valid bits: squash first, then pop clear, then push set. The push slot
    // is never the head of a non-empty FIFO, so the later writes never collide
    // with a live entry that should survive.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            fifo_vld <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (alu_wr && (fifo_a[i] == ALU_A))
                    fifo_vld[i] <= 1'b0;
            if (pop) begin
                fifo_vld[rptr] <= 1'b0;
                rptr           <= rptr + 1'b1;
            end
            if (lsu_push) begin
                // Same-cycle ALU write to the same register is newer.
                fifo_vld[wptr] <= (LSU_A != 5'd0) && !(alu_wr && (ALU_A == LSU_A));
                wptr           <= wptr + 1'b1;
            end
            case ({lsu_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- output stage ----------------
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            A3  <= '0;
            WD3 <= '0;
            WE3 <= 1'b0;
        end else if (pop) begin
            A3  <= fifo_a[rptr];
            WD3 <= fifo_d[rptr];
            WE3 <= fifo_vld[rptr];
        end else if (alu_wr) begin
            A3  <= ALU_A;
            WD3 <= ALU_D;
            WE3 <= 1'b1;
        end else begin
            WE3 <= 1'b0;
        end
    end

    // ---------------- bypass ----------------
    // Output stage is older than anything in the FIFO; FIFO entries are
    // scanned oldest to youngest so the youngest live match wins.
    always_comb begin
        BYP1_HIT = 1'b0;
        BYP1_D   = '0;
        BYP2_HIT = 1'b0;
        BYP2_D   = '0;
        if (WE3 && (A3 == A1) && (A1 != 5'd0)) begin
            BYP1_HIT = 1'b1;
            BYP1_D   = WD3;
        end
        if (WE3 && (A3 == A2) && (A2 != 5'd0)) begin
            BYP2_HIT = 1'b1;
            BYP2_D   = WD3;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) && fifo_vld[rptr + AW'(k)]) begin
                if ((fifo_a[rptr + AW'(k)] == A1) && (A1 != 5'd0)) begin
                    BYP1_HIT = 1'b1;
                    BYP1_D   = fifo_d[rptr + AW'(k)];
                end
                if ((fifo_a[rptr + AW'(k)] == A2) && (A2 != 5'd0)) begin
                    BYP2_HIT = 1'b1;
                    BYP2_D   = fifo_d[rptr + AW'(k)];
                end
            end
        end
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Write-side front end for the 3-port register file. Merges results from the single-cycle ALU path and the variable-latency load/store path (LSU) into the single write port (A3/WD3/WE3).
- Buffers LSU results in a small in-order FIFO and squashes stale writes (WAW).
- Provides bypass data for the two read addresses, covering values not yet committed to the register file.

Parameters:
- DEPTH, 4, LSU result FIFO entries (power of two, >=2)
- STARVE_MAX, 8, cycles a live FIFO head may wait before a forced LSU drain cycle

Ports:
- CLK  in  1  system clock, rising edge
- RESETn  in  1  synchronous reset, active-low
- ALU_V  in  1  ALU result valid
- ALU_A  in  5  ALU destination register
- ALU_D  in  32  ALU result
- ALU_RDY  out  1  ALU result accepted this cycle when ALU_V&&ALU_RDY
- LSU_V  in  1  LSU result valid
- LSU_A  in  5  LSU destination register
- LSU_D  in  32  LSU result
- LSU_RDY  out  1  LSU result accepted when LSU_V&&LSU_RDY
- A3  out  5  register file write address (registered)
- WD3  out  32  register file write data (registered)
- WE3  out  1  register file write enable (registered)
- A1, A2  in  5  register file read addresses to check for bypass
- BYP1_HIT, BYP2_HIT  out  1  pending newer value exists for A1/A2
- BYP1_D, BYP2_D  out  32  bypass data (0 when no hit)

Behaviour:
- Reset (RESETn=0 at a rising edge): A3=0, WD3=0, WE3=0, FIFO empty with all entry valid bits cleared, starve counter=0, state=NORMAL. Reset overrides any in-flight handshake; accepted-but-uncommitted data is discarded.
- Outputs during reset cycles: ALU_RDY=0, LSU_RDY=0.
- Register 0: any write with address 0 is accepted (handshake completes) but never stored or driven with WE3=1.
- State machine:
  - NORMAL: ALU_RDY=1.
  - DRAIN: entered when starve counter==STARVE_MAX-1 and a live FIFO head is still not selected. ALU_RDY=0, the FIFO head is popped, and the state returns to NORMAL next cycle.
- Starve counter: increments each NORMAL cycle in which the FIFO head is live and not popped; clears on pop or when the FIFO is empty.
- Output-stage selection at each edge, in priority order:
  1. DRAIN: pop the head.
  2. NORMAL with ALU accept and ALU_A!=0: load the ALU result.
  3. Otherwise, FIFO non-empty: pop the head.
  4. Otherwise: WE3<=0.
- A popped head whose valid bit is cleared (killed) gives WE3<=0 and still consumes the slot.
- Latency: ALU result reaches WE3 one cycle after acceptance. An LSU result reaches WE3 at least one cycle after acceptance (no pass-through from LSU input to output stage).
- LSU_RDY = !full (during reset: 0). Simultaneous pop does not raise LSU_RDY in the same cycle. Push and pop in the same cycle are legal when not full.
- WAW squash: an ALU accept with address X clears the valid bit of every FIFO entry with address X. An LSU entry pushed in the same cycle with address X is stored killed, because the ALU result is the newer one.
- FIFO pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- Bypass (combinational), for each port n with Ax=A1/A2:
  - Ax==0: no hit.
  - Otherwise, if the youngest live FIFO entry has address Ax: hit, with that entry's data.
  - Otherwise, if WE3 && A3==Ax: hit, with WD3.
  - Otherwise: HIT=0, D=0.
  - Bypass sees state only (registered FIFO/output stage), never same-cycle ALU/LSU inputs.

Test Plan:
- Reset then ALU_V=1, ALU_A=5, ALU_D=0x1234 for 1 cycle -> next cycle WE3=1, A3=5, WD3=0x1234; following cycle WE3=0.
- ALU_A=0, ALU_D=0xFFFF_FFFF with ALU_V=1 -> ALU_RDY=1, WE3 never asserts; A1=0 gives BYP1_HIT=0.
- Push LSU results to r1..r4 (DEPTH=4) while ALU_V=1 every cycle to r9 -> LSU_RDY drops after 4 pushes. After STARVE_MAX cycles, one DRAIN cycle with ALU_RDY=0 and WE3=1, A3=1. Writes commit in order r1..r4 across successive drains.
- LSU push r7=0xAAAA, then ALU accept r7=0xBBBB before drain -> BYP1_HIT with A1=7 returns 0xBBBB. The popped r7 LSU entry produces WE3=0, and the final register value is 0xBBBB.
- Same-cycle ALU and LSU both targeting r3 (ALU 0x11, LSU 0x22) -> only 0x11 is written; LSU entry killed; LSU_RDY handshake completes.
- FIFO holding 3 live entries, RESETn=0 for one edge -> WE3=0, LSU_RDY=1 after release, no stale write ever appears on A3/WD3.
